// File: rtl/memory_cache.sv
// Split direct-mapped I/D caches (4-word lines, write-through D side) over one shared main memory.
// Main memory is initialised to mem[i] = 16'h1000 + i; MEM_INIT_FILE is unused.
module memory_cache #(
    parameter int    LINES         = 16,
    parameter int    MEM_LAT       = 4,
    parameter int    MEM_AW        = 12,
    parameter string MEM_INIT_FILE = "mem.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [15:0] I_addr,
    output logic [15:0] I_Data_out,
    input  logic [15:0] Data_addr,
    input  logic [15:0] D_Data_in,
    output logic [15:0] D_Data_out,
    output logic        Stall
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - IDX_W - 2;
    localparam int CNT_W = $clog2(MEM_LAT);

    typedef enum logic [1:0] {IDLE, D_FILL, I_FILL, D_WRITE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       word_q, word_d;
    logic             d_done_q, d_done_d;
    logic [LINES-1:0] i_valid_q, i_valid_d, d_valid_q, d_valid_d;

    logic [TAG_W-1:0] i_tag_q [LINES];
    logic [TAG_W-1:0] d_tag_q [LINES];
    logic [15:0]      i_data_q [LINES][4];
    logic [15:0]      d_data_q [LINES][4];
    logic [15:0]      mem_q [2**MEM_AW];

    logic [IDX_W-1:0]  i_idx, d_idx;
    logic [TAG_W-1:0]  i_tag, d_tag;
    logic [1:0]        i_off, d_off;
    logic              i_hit, d_hit, is_lw, is_sw, i_miss, d_miss, last_cnt;
    logic [MEM_AW-1:0] fill_addr;
    logic [15:0]       fill_word;
    logic              i_fill_we, d_fill_we, i_line_done, d_line_done, mem_we, d_store_we;

    assign i_idx = I_addr[IDX_W+1:2];
    assign i_tag = I_addr[15:IDX_W+2];
    assign i_off = I_addr[1:0];
    assign d_idx = Data_addr[IDX_W+1:2];
    assign d_tag = Data_addr[15:IDX_W+2];
    assign d_off = Data_addr[1:0];

    assign i_hit  = i_valid_q[i_idx] && (i_tag_q[i_idx] == i_tag);
    assign d_hit  = d_valid_q[d_idx] && (d_tag_q[d_idx] == d_tag);
    assign is_lw  = (opcode == 4'b1000);
    assign is_sw  = (opcode == 4'b1001);
    assign i_miss = !i_hit;
    assign d_miss = is_lw && !d_hit;

    assign last_cnt  = (cnt_q == CNT_W'(MEM_LAT - 1));
    assign fill_addr = (state_q == D_FILL) ? {Data_addr[MEM_AW-1:2], word_q}
                                           : {I_addr[MEM_AW-1:2], word_q};
    assign fill_word = mem_q[fill_addr];

    assign I_Data_out = i_hit ? i_data_q[i_idx][i_off] : 16'h0000;
    assign D_Data_out = (is_lw && d_hit) ? d_data_q[d_idx][d_off] : 16'h0000;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        d_done_d    = d_done_q;
        i_valid_d   = i_valid_q;
        d_valid_d   = d_valid_q;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_line_done = 1'b0;
        d_line_done = 1'b0;
        mem_we      = 1'b0;
        d_store_we  = 1'b0;
        Stall       = i_miss || ((d_miss || is_sw) && !d_done_q);
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                word_d = 2'd0;
                if (!d_done_q && d_miss)     state_d = D_FILL;
                else if (!d_done_q && is_sw) state_d = D_WRITE;
                else if (i_miss)             state_d = I_FILL;
            end
            D_FILL, I_FILL: begin
                Stall = 1'b1;
                if (last_cnt) begin
                    cnt_d     = '0;
                    word_d    = word_q + 2'd1;
                    d_fill_we = (state_q == D_FILL);
                    i_fill_we = (state_q == I_FILL);
                    if (word_q == 2'd3) begin
                        d_line_done = d_fill_we;
                        i_line_done = i_fill_we;
                        if (d_fill_we) d_valid_d[d_idx] = 1'b1;
                        if (i_fill_we) i_valid_d[i_idx] = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            D_WRITE: begin
                // Store commits in its last cycle, which the pipeline may already use.
                if (last_cnt) begin
                    Stall      = i_miss;
                    mem_we     = 1'b1;
                    d_store_we = d_hit;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    Stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!Stall)      d_done_d = 1'b0;
        else if (mem_we) d_done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= 2'd0;
            d_done_q  <= 1'b0;
            i_valid_q <= '0;
            d_valid_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            d_done_q  <= d_done_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_we)   i_data_q[i_idx][word_q] <= fill_word;
        if (i_line_done) i_tag_q[i_idx] <= i_tag;
        if (d_fill_we)   d_data_q[d_idx][word_q] <= fill_word;
        if (d_line_done) d_tag_q[d_idx] <= d_tag;
        if (d_store_we)  d_data_q[d_idx][d_off] <= D_Data_in;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[Data_addr[MEM_AW-1:0]] <= D_Data_in;
    end

    initial begin
        for (int i = 0; i < 2**MEM_AW; i++) mem_q[i] = 16'(16'h1000 + i);
    end
endmodule

// File: tb/tb_memory_cache.sv
// Randomised scoreboard bench for memory_cache against a block-level cache model.
module tb_memory_cache;
  localparam int LINES   = 16;
  localparam int MEM_LAT = 4;
  localparam int MEM_AW  = 12;
  localparam int MSIZE   = 2**MEM_AW;
  localparam int FILL    = 1 + 4*MEM_LAT;
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] i_addr = 16'd0;
  logic [15:0] data_addr = 16'd0;
  logic [15:0] d_data_in = 16'd0;
  logic [15:0] i_data_out, d_data_out;
  logic        stall;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  bit mon_en = 1'b0;

  logic [15:0] exp_i_q[$];
  logic [15:0] exp_d_q[$];
  int          exp_s_q[$];

  // reference model: each line remembers which block (addr / 4) it holds
  logic [15:0] m_mem [MSIZE];
  bit          m_iv [LINES];
  bit          m_dv [LINES];
  int          m_iblk [LINES];
  int          m_dblk [LINES];
  logic [15:0] m_idat [LINES][4];
  logic [15:0] m_ddat [LINES][4];

  always #5 clk = ~clk;

  memory_cache #(.LINES(LINES), .MEM_LAT(MEM_LAT), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .I_addr(i_addr), .I_Data_out(i_data_out),
    .Data_addr(data_addr), .D_Data_in(d_data_in), .D_Data_out(d_data_out), .Stall(stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_invalidate();
    for (int l = 0; l < LINES; l++) begin
      m_iv[l] = 1'b0;
      m_dv[l] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] da,
                            input logic [15:0] dd);
    int stalls = 0;
    int ib = int'(ia) / 4;
    int db = int'(da) / 4;
    int il = ib % LINES;
    int dl = db % LINES;
    bit ihit = m_iv[il] && (m_iblk[il] == ib);
    bit dhit = m_dv[dl] && (m_dblk[dl] == db);
    logic [15:0] ed = 16'h0000;
    if (op == OP_LW) begin
      if (!dhit) begin
        stalls += FILL;
        m_dv[dl] = 1'b1;
        m_dblk[dl] = db;
        for (int w = 0; w < 4; w++) m_ddat[dl][w] = m_mem[(db*4 + w) % MSIZE];
      end
      ed = m_ddat[dl][int'(da) % 4];
    end else if (op == OP_SW) begin
      stalls += MEM_LAT + (ihit ? 0 : 1);
      m_mem[int'(da) % MSIZE] = dd;
      if (dhit) m_ddat[dl][int'(da) % 4] = dd;
    end
    if (!ihit) begin
      stalls += FILL;
      m_iv[il] = 1'b1;
      m_iblk[il] = ib;
      for (int w = 0; w < 4; w++) m_idat[il][w] = m_mem[(ib*4 + w) % MSIZE];
    end
    exp_i_q.push_back(m_idat[il][int'(ia) % 4]);
    exp_d_q.push_back(ed);
    exp_s_q.push_back(stalls);
  endtask

  task automatic report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] da,
                       input logic [15:0] dd);
    int start = acc_cnt;
    int n = 0;
    opcode = op;
    i_addr = ia;
    data_addr = da;
    d_data_in = dd;
    model_step(op, ia, da, dd);
    while (acc_cnt == start && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (acc_cnt == start) begin
      total++;
      bad++;
      $display("FAIL timeout: op=%h i_addr=%h data_addr=%h still stalled after %0d cycles", op, ia, da, n);
      report();
    end
    #1;
  endtask

  // monitor: counts stalled cycles, checks outputs when the pipeline is released
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
    end else begin
      if (exp_s_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept: got stall=0 expected no transaction");
      end else begin
        check("stall_cycles", 32'(stall_cnt), 32'(exp_s_q.pop_front()));
        check("i_data_out", 32'(i_data_out), 32'(exp_i_q.pop_front()));
        check("d_data_out", 32'(d_data_out), 32'(exp_d_q.pop_front()));
      end
      stall_cnt = 0;
      acc_cnt++;
    end
  end

  function automatic logic [15:0] rand_addr();
    logic [15:0] a = 16'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) a[12] = 1'b1;
    return a;
  endfunction

  initial begin
    logic [3:0] op;
    for (int i = 0; i < MSIZE; i++) m_mem[i] = 16'(16'h1000 + i);
    model_invalidate();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd1);
    check("reset_i_data", 32'(i_data_out), 32'h0);
    check("reset_d_data", 32'(d_data_out), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    issue(4'd0, 16'h0000, 16'h0000, 16'h0000);
    issue(4'd0, 16'h0001, 16'h0000, 16'h0000);
    issue(OP_SW, 16'h0001, 16'h0001, 16'hBEEF);
    issue(OP_LW, 16'h0001, 16'h0001, 16'h0000);
    issue(OP_LW, 16'h0001, 16'h0084, 16'h0000);
    issue(OP_SW, 16'h0001, 16'h0084, 16'h1234);
    issue(OP_LW, 16'h0001, 16'h0084, 16'h0000);
    issue(OP_LW, 16'h0001, 16'h0000, 16'h0000);
    issue(OP_LW, 16'h0001, 16'h0040, 16'h0000);
    issue(OP_LW, 16'h0001, 16'h0000, 16'h0000);
    issue(OP_LW, 16'h0010, 16'h0020, 16'h0000);
    issue(OP_SW, 16'h0030, 16'h0031, 16'h5A5A);
    issue(OP_SW, 16'h0030, 16'h0032, 16'hA5A5);

    // reset in the middle of an instruction fill
    mon_en = 1'b0;
    opcode = 4'd0;
    i_addr = 16'h0300;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_invalidate();
    mon_en = 1'b1;
    issue(4'd0, 16'h0300, 16'h0000, 16'h0000);
    issue(4'd0, 16'h0000, 16'h0000, 16'h0000);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OP_LW;
        4, 5:       op = OP_SW;
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op == OP_LW || op == OP_SW) op = 4'd0;
        end
      endcase
      issue(op, rand_addr(), rand_addr(), 16'($urandom));
    end

    mon_en = 1'b0;
    check("queue_drained", 32'(exp_s_q.size()), 32'd0);
    report();
  end
endmodule
